// File: rtl/st7920_serial_lcd_driver.sv
// ST7920 serial-mode driver: power-up wait, init, then endless refresh of a
// 128x64 mono framebuffer. Ports: clk_in, rst_in (sync, active-low), vram,
// lcd_clk (SCLK), lcd_data (SID), led[5:0] (active-low status).
module st7920_serial_lcd_driver #(
   parameter int HALF_SCLK = 14,
   parameter int CMD_WAIT  = 2700,
   parameter int CLR_WAIT  = 54000,
   parameter int PWR_WAIT  = 1080000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] vram [0:1023],
   output logic       lcd_clk,
   output logic       lcd_data,
   output logic [5:0] led
);

   localparam int MAX_A = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
   localparam int MAX_W = (MAX_A > CMD_WAIT) ? MAX_A : CMD_WAIT;
   localparam int CW    = $clog2(MAX_W + 1);
   localparam int HW    = (HALF_SCLK > 1) ? $clog2(HALF_SCLK) : 1;

   localparam logic [CW-1:0] PWR_LAST  = CW'(PWR_WAIT - 1);
   localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WAIT - 1);
   localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_WAIT - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_SCLK - 1);

   typedef enum logic [2:0] {
      S_PWR, S_INIT, S_SET_Y, S_SET_X, S_DATA
   } seq_t;

   typedef enum logic [1:0] {
      X_IDLE, X_SHIFT, X_WAIT
   } xfer_t;

   seq_t          seq_q, seq_d;
   xfer_t         xfer_q, xfer_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] half_q, half_d;
   logic          phase_q, phase_d;
   logic [4:0]    bit_q, bit_d;
   logic [22:0]   sr_q, sr_d;
   logic [4:0]    idx_q, idx_d;
   logic [4:0]    y_q, y_d;
   logic          frame_q, frame_d;
   logic          init_done_q, init_done_d;
   logic          clr_q, clr_d;
   logic          lcd_clk_q, lcd_clk_d;
   logic          lcd_data_q, lcd_data_d;

   logic [7:0]    init_cmd;
   logic [7:0]    cur_byte;
   logic          cur_is_data;
   logic [9:0]    vaddr;
   logic [23:0]   frame_word;

   always_comb begin
      unique case (idx_q[2:0])
         3'd0:    init_cmd = 8'h30;
         3'd1:    init_cmd = 8'h30;
         3'd2:    init_cmd = 8'h0C;
         3'd3:    init_cmd = 8'h01;
         3'd4:    init_cmd = 8'h06;
         3'd5:    init_cmd = 8'h34;
         default: init_cmd = 8'h36;
      endcase
   end

   // idx[4] picks the bottom half (rows 32..63), idx[3:0] the byte column
   assign vaddr       = {idx_q[4], y_q, idx_q[3:0]};
   assign cur_is_data = (seq_q == S_DATA);

   always_comb begin
      cur_byte = 8'h00;
      unique case (seq_q)
         S_INIT:  cur_byte = init_cmd;
         S_SET_Y: cur_byte = {3'b100, y_q};
         S_SET_X: cur_byte = 8'h80;
         S_DATA:  cur_byte = vram[vaddr];
         default: cur_byte = 8'h00;
      endcase
   end

   assign frame_word = {cur_is_data ? 8'hFA : 8'hF8,
                        cur_byte[7:4], 4'b0000,
                        cur_byte[3:0], 4'b0000};

   always_comb begin
      seq_d       = seq_q;
      xfer_d      = xfer_q;
      cnt_d       = cnt_q;
      half_d      = half_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      sr_d        = sr_q;
      idx_d       = idx_q;
      y_d         = y_q;
      frame_d     = frame_q;
      init_done_d = init_done_q;
      clr_d       = clr_q;
      lcd_clk_d   = lcd_clk_q;
      lcd_data_d  = lcd_data_q;

      if (seq_q == S_PWR) begin
         if (cnt_q == PWR_LAST) begin
            seq_d = S_INIT;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         unique case (xfer_q)
            X_IDLE: begin
               // byte is captured here; the first bit's low phase starts now
               sr_d       = frame_word[22:0];
               lcd_data_d = frame_word[23];
               lcd_clk_d  = 1'b0;
               half_d     = '0;
               phase_d    = 1'b0;
               bit_d      = 5'd0;
               clr_d      = !cur_is_data && (cur_byte == 8'h01);
               xfer_d     = X_SHIFT;
            end
            X_SHIFT: begin
               if (half_q == HALF_LAST) begin
                  half_d = '0;
                  if (!phase_q) begin
                     phase_d   = 1'b1;
                     lcd_clk_d = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     lcd_clk_d = 1'b0;
                     if (bit_q == 5'd23) begin
                        lcd_data_d = 1'b0;
                        cnt_d      = '0;
                        xfer_d     = X_WAIT;
                     end else begin
                        bit_d      = bit_q + 5'd1;
                        lcd_data_d = sr_q[22];
                        sr_d       = {sr_q[21:0], 1'b0};
                     end
                  end
               end else begin
                  half_d = half_q + 1'b1;
               end
            end
            X_WAIT: begin
               if (cnt_q == (clr_q ? CLR_LAST : CMD_LAST)) begin
                  cnt_d  = '0;
                  xfer_d = X_IDLE;
                  unique case (seq_q)
                     S_INIT: begin
                        if (idx_q == 5'd6) begin
                           seq_d       = S_SET_Y;
                           idx_d       = 5'd0;
                           y_d         = 5'd0;
                           init_done_d = 1'b1;
                        end else begin
                           idx_d = idx_q + 5'd1;
                        end
                     end
                     S_SET_Y: seq_d = S_SET_X;
                     S_SET_X: begin
                        seq_d = S_DATA;
                        idx_d = 5'd0;
                     end
                     S_DATA: begin
                        if (idx_q == 5'd31) begin
                           seq_d = S_SET_Y;
                           idx_d = 5'd0;
                           if (y_q == 5'd31) begin
                              y_d     = 5'd0;
                              frame_d = ~frame_q;
                           end else begin
                              y_d = y_q + 5'd1;
                           end
                        end else begin
                           idx_d = idx_q + 5'd1;
                        end
                     end
                     default: seq_d = S_PWR;
                  endcase
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: xfer_d = X_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         seq_q       <= S_PWR;
         xfer_q      <= X_IDLE;
         cnt_q       <= '0;
         half_q      <= '0;
         phase_q     <= 1'b0;
         bit_q       <= 5'd0;
         sr_q        <= '0;
         idx_q       <= 5'd0;
         y_q         <= 5'd0;
         frame_q     <= 1'b0;
         init_done_q <= 1'b0;
         clr_q       <= 1'b0;
         lcd_clk_q   <= 1'b0;
         lcd_data_q  <= 1'b0;
      end else begin
         seq_q       <= seq_d;
         xfer_q      <= xfer_d;
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         sr_q        <= sr_d;
         idx_q       <= idx_d;
         y_q         <= y_d;
         frame_q     <= frame_d;
         init_done_q <= init_done_d;
         clr_q       <= clr_d;
         lcd_clk_q   <= lcd_clk_d;
         lcd_data_q  <= lcd_data_d;
      end
   end

   assign lcd_clk  = lcd_clk_q;
   assign lcd_data = lcd_data_q;
   assign led      = {4'b1111, ~frame_q, ~init_done_q};

endmodule

// File: tb/tb_st7920_serial_lcd_driver.sv
// Bench for st7920_serial_lcd_driver: one instance with the nominal test
// timing, one with minimal timing to cover a full refresh and wrap.
`timescale 1ns/1ps
module tb_st7920_serial_lcd_driver;

   localparam int HS = 2, CWT = 10, CLW = 20, PW = 50;
   localparam int B_HS = 1, B_CW = 1, B_CLW = 2, B_PW = 5;
   localparam int B_FRAMES = 7 + 32 * 34 + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0, rst_b = 1'b0;
   logic [7:0] vram_a [0:1023];
   logic [7:0] vram_b [0:1023];
   logic clk_a, dat_a, clk_b, dat_b;
   logic [5:0] led_a, led_b;

   st7920_serial_lcd_driver #(
      .HALF_SCLK(HS), .CMD_WAIT(CWT), .CLR_WAIT(CLW), .PWR_WAIT(PW)
   ) dut_a (
      .clk_in(clk), .rst_in(rst_a), .vram(vram_a),
      .lcd_clk(clk_a), .lcd_data(dat_a), .led(led_a)
   );

   st7920_serial_lcd_driver #(
      .HALF_SCLK(B_HS), .CMD_WAIT(B_CW), .CLR_WAIT(B_CLW), .PWR_WAIT(B_PW)
   ) dut_b (
      .clk_in(clk), .rst_in(rst_b), .vram(vram_b),
      .lcd_clk(clk_b), .lcd_data(dat_b), .led(led_b)
   );

   typedef struct {
      logic [23:0] frame;
      int          low;
      logic [5:0]  led;
   } rx_t;

   typedef struct {
      string       nm;
      logic [23:0] frame;
      int          min_low;
      logic        led0;
   } vec_t;

   typedef struct {
      logic [23:0] frame;
      int          min_low;
      logic [5:0]  led;
   } exp_t;

   rx_t  qa[$];
   rx_t  qb[$];
   vec_t tbl [26];
   exp_t expb[$];

   int checks = 0, errors = 0;

   int nb_a = 0, low_a = 0, fl_a = 0, hv_a = 0;
   logic [23:0] acc_a = '0;
   logic pc_a = 1'b0, pd_a = 1'b0;

   int nb_b = 0, low_b = 0, fl_b = 0;
   logic [23:0] acc_b = '0;
   logic pc_b = 1'b0;

   // frame decoders: bits sampled on lcd_clk rises, low time before frame
   always @(negedge clk) begin
      if (!rst_a) begin
         nb_a = 0; acc_a = '0; low_a = 0; pc_a = 0; pd_a = 0;
         qa.delete();
      end else begin
         if (clk_a && !pc_a) begin
            acc_a = {acc_a[22:0], dat_a};
            if (nb_a == 0) fl_a = low_a;
            nb_a++;
            if (nb_a == 24) begin
               qa.push_back('{acc_a, fl_a, led_a});
               nb_a = 0;
            end
         end
         if (clk_a && pc_a && (dat_a !== pd_a)) hv_a++;
         low_a = clk_a ? 0 : low_a + 1;
         pc_a = clk_a;
         pd_a = dat_a;
      end
   end

   always @(negedge clk) begin
      if (!rst_b) begin
         nb_b = 0; acc_b = '0; low_b = 0; pc_b = 0;
         qb.delete();
      end else begin
         if (clk_b && !pc_b) begin
            acc_b = {acc_b[22:0], dat_b};
            if (nb_b == 0) fl_b = low_b;
            nb_b++;
            if (nb_b == 24) begin
               qb.push_back('{acc_b, fl_b, led_b});
               nb_b = 0;
            end
         end
         low_b = clk_b ? 0 : low_b + 1;
         pc_b = clk_b;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_ge(input string nm, input int act, input int min);
      checks++;
      if (act < min) begin
         errors++;
         $display("FAIL %s: got %0d expected >= %0d", nm, act, min);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out", nm);
   endtask

   task automatic wait_qa(input int n, input int budget, input string nm);
      int c = 0;
      while (qa.size() < n && c < budget) begin
         @(negedge clk); #1;
         c++;
      end
      if (qa.size() < n) timeout(nm);
   endtask

   task automatic check_table(input int n, input string tag);
      int m = (qa.size() < n) ? qa.size() : n;
      for (int i = 0; i < m; i++) begin
         chk($sformatf("%s %s[%0d] frame", tag, tbl[i].nm, i),
             32'(qa[i].frame), 32'(tbl[i].frame));
         chk_ge($sformatf("%s %s[%0d] gap", tag, tbl[i].nm, i),
                qa[i].low, tbl[i].min_low);
         chk($sformatf("%s %s[%0d] led0", tag, tbl[i].nm, i),
             32'(qa[i].led[0]), 32'(tbl[i].led0));
         chk($sformatf("%s %s[%0d] led5_2", tag, tbl[i].nm, i),
             32'(qa[i].led[5:2]), 32'hF);
      end
   endtask

   function automatic logic [23:0] fr(input bit d, input logic [7:0] b);
      return {d ? 8'hFA : 8'hF8, b[7:4], 4'h0, b[3:0], 4'h0};
   endfunction

   bit prev_clr = 0;
   task automatic push_b(input bit d, input logic [7:0] b);
      int i = expb.size();
      int ml = (i == 0) ? B_PW : (prev_clr ? B_CLW : B_CW);
      logic l1 = (i >= 7 + 32 * 34) ? 1'b0 : 1'b1;
      logic l0 = (i >= 7) ? 1'b0 : 1'b1;
      expb.push_back('{fr(d, b), ml, {4'hF, l1, l0}});
      prev_clr = !d && (b == 8'h01);
   endtask

   initial begin
      logic [7:0] init_seq [7];
      init_seq = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06, 8'h34, 8'h36};

      tbl[0] = '{"init30a", 24'hF83000, PW,  1'b1};
      tbl[1] = '{"init30b", 24'hF83000, CWT, 1'b1};
      tbl[2] = '{"init0C",  24'hF800C0, CWT, 1'b1};
      tbl[3] = '{"init01",  24'hF80010, CWT, 1'b1};
      tbl[4] = '{"init06",  24'hF80060, CLW, 1'b1};
      tbl[5] = '{"init34",  24'hF83040, CWT, 1'b1};
      tbl[6] = '{"init36",  24'hF83060, CWT, 1'b1};
      tbl[7] = '{"sety0",   24'hF88000, CWT, 1'b0};
      tbl[8] = '{"setx",    24'hF88000, CWT, 1'b0};
      tbl[9] = '{"dataA5",  24'hFAA050, CWT, 1'b0};
      for (int i = 10; i < 25; i++)
         tbl[i] = '{"data00", 24'hFA0000, CWT, 1'b0};
      tbl[25] = '{"data3C", 24'hFA30C0, CWT, 1'b0};

      for (int i = 0; i < 1024; i++) begin
         vram_a[i] = 8'h00;
         vram_b[i] = 8'($urandom);
      end
      vram_a[0]   = 8'hA5;
      vram_a[512] = 8'h3C;
      vram_b[16 * 31 + 15] = 8'h81;

      for (int i = 0; i < 7; i++) push_b(0, init_seq[i]);
      for (int y = 0; y < 32; y++) begin
         push_b(0, 8'h80 | 8'(y));
         push_b(0, 8'h80);
         for (int j = 0; j < 32; j++)
            push_b(1, (j < 16) ? vram_b[16 * y + j]
                               : vram_b[512 + 16 * y + j - 16]);
      end
      push_b(0, 8'h80);

      repeat (5) begin
         @(negedge clk); #1;
         chk("reset lcd_clk", 32'(clk_a), 0);
         chk("reset lcd_data", 32'(dat_a), 0);
         chk("reset led", 32'(led_a), 32'h3F);
      end
      @(posedge clk); #1;
      rst_a = 1'b1;
      rst_b = 1'b1;

      fork
         begin : seq_a
            int c;
            c = 0;
            while (!(qa.size() == 9 && nb_a >= 1) && c < 4000) begin
               @(negedge clk); #1;
               c++;
            end
            if (qa.size() == 9 && nb_a >= 1) vram_a[0] = 8'h00;
            else timeout("reach data0");
            wait_qa(10, 400, "data0 done");
            vram_a[0] = 8'hA5;
            wait_qa(26, 4000, "run1 frames");
            check_table(26, "run1");

            c = 0;
            while (!(qa.size() == 26 && nb_a == 11) && c < 400) begin
               @(negedge clk); #1;
               c++;
            end
            if (qa.size() == 26 && nb_a == 11) begin
               chk("pre-reset lcd_clk high", 32'(clk_a), 1);
               rst_a = 1'b0;
               @(negedge clk); #1;
               chk("midframe lcd_clk", 32'(clk_a), 0);
               chk("midframe lcd_data", 32'(dat_a), 0);
               chk("midframe led", 32'(led_a), 32'h3F);
               repeat (3) @(negedge clk);
               #1;
               chk("held lcd_clk", 32'(clk_a), 0);
               chk("held led", 32'(led_a), 32'h3F);
            end else begin
               timeout("reach bit 10");
               rst_a = 1'b0;
               repeat (3) @(negedge clk);
            end
            @(posedge clk); #1;
            rst_a = 1'b1;
            wait_qa(10, 2000, "run2 frames");
            check_table(10, "run2");
         end
         begin : seq_b
            int c, n;
            c = 0;
            while (qb.size() < B_FRAMES && c < 70000) begin
               @(negedge clk); #1;
               c++;
            end
            if (qb.size() < B_FRAMES) timeout("refresh frames");
            n = (qb.size() < B_FRAMES) ? qb.size() : B_FRAMES;
            for (int i = 0; i < n; i++) begin
               chk($sformatf("ref frame[%0d]", i),
                   32'(qb[i].frame), 32'(expb[i].frame));
               chk_ge($sformatf("ref gap[%0d]", i),
                      qb[i].low, expb[i].min_low);
               chk($sformatf("ref led[%0d]", i),
                   32'(qb[i].led), 32'(expb[i].led));
            end
            if (qb.size() >= B_FRAMES) begin
               chk("sety31", 32'(qb[7 + 31 * 34].frame), 32'hF890F0);
               chk("y31 byte15", 32'(qb[7 + 31 * 34 + 17].frame),
                   32'hFA8010);
               chk("wrap sety0", 32'(qb[B_FRAMES - 1].frame), 32'hF88000);
               chk("led1 before wrap", 32'(qb[B_FRAMES - 2].led[1]), 1);
               chk("led1 after wrap", 32'(qb[B_FRAMES - 1].led[1]), 0);
            end
         end
      join

      chk("data stable in high phase", 32'(hv_a), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/st7920_serial_lcd_driver.md
ST7920_SERIAL_LCD_DRIVER -- requirements
Module: st7920_serial_lcd_driver

Interface
REQ-001 SHALL have parameter HALF_SCLK, default 14: system clocks per lcd_clk half-period.
REQ-002 SHALL have parameter CMD_WAIT, default 2700: idle clocks after each command or data transfer.
REQ-003 SHALL have parameter CLR_WAIT, default 54000: idle clocks after the clear command (0x01).
REQ-004 SHALL have parameter PWR_WAIT, default 1080000: idle clocks after reset before the first transfer.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port vram, input, unpacked array [0:1023] of 8 bits: 128x64 mono framebuffer.
  - Pixel (col, row) is byte (row*128+col)/8, bit 7-((row*128+col)%8).
REQ-008 SHALL have port lcd_clk, output, 1 bit: ST7920 SCLK.
REQ-009 SHALL have port lcd_data, output, 1 bit: ST7920 SID.
REQ-010 SHALL have port led, output, 6 bits: active-low status LEDs.

Function
REQ-011 SHALL send each byte as one 24-bit serial frame, MSB first:
  - frame = sync, {b[7:4],4'b0000}, {b[3:0],4'b0000};
  - sync = 0xF8 for a command, 0xFA for a data byte.
REQ-012 SHALL clock each bit as HALF_SCLK clocks with lcd_clk=0 then HALF_SCLK clocks with lcd_clk=1.
  - lcd_data changes only at the start of the low phase and holds through the high phase (LCD samples on the rising edge).
REQ-013 SHALL hold lcd_clk=0 and lcd_data=0 between frames.
REQ-014 SHALL, after each frame, idle CMD_WAIT clocks, or CLR_WAIT clocks after command 0x01, before the next frame.
REQ-015 SHALL run this state machine: PWR -> INIT -> SET_Y -> SET_X -> DATA -> SET_Y ...
REQ-016 PWR SHALL count PWR_WAIT clocks, then enter INIT.
REQ-017 INIT SHALL send the commands 0x30, 0x30, 0x0C, 0x01, 0x06, 0x34, 0x36 in order, then enter SET_Y with y=0.
REQ-018 SET_Y SHALL send command 0x80|y, with y 0..31.
REQ-019 SET_X SHALL send command 0x80.
REQ-020 DATA SHALL send 32 data bytes for the current y:
  - bytes 0-15 are vram[16*y + k] (top half, row y);
  - bytes 16-31 are vram[512 + 16*y + k] (bottom half, row y+32);
  - k runs 0..15.
REQ-021 SHALL, after DATA, increment y; after y=31, wrap y to 0 and toggle the frame flag, refreshing continuously with no further INIT.
REQ-022 SHALL latch each vram byte into the shift register at the first clock of its frame; later vram changes do not alter a frame in progress.
REQ-023 SHALL drive led[0]=0 once INIT has completed, else 1.
REQ-024 SHALL drive led[1] as the inverted frame flag, toggling once per full frame of 32 SET_Y/SET_X/DATA groups.
REQ-025 SHALL drive led[5:2]=4'b1111.
REQ-026 SHALL keep internal counters wide enough for PWR_WAIT; all counts are unsigned and contain no overflow wrap.

Reset
REQ-027 SHALL, on any clock edge with rst_in=0, set:
  - lcd_clk=0, lcd_data=0, led=6'b111111;
  - state=PWR, all counters=0, y=0, frame flag=0.
REQ-028 SHALL apply reset taken mid-frame or mid-wait on the next edge, abandoning the frame.
  - After reset release, the first lcd_clk rise occurs no earlier than PWR_WAIT clocks later.
REQ-029 SHALL hold the reset state for as long as rst_in=0.

Verification
Run with HALF_SCLK=2, CMD_WAIT=10, CLR_WAIT=20, PWR_WAIT=50 for all scenarios.
REQ-030 Hold rst_in=0 for 5 clocks -> lcd_clk=0, lcd_data=0, led=111111 throughout.
REQ-031 Release reset -> lcd_clk stays 0 for >=50 clocks.
  - First 24 bits sampled on lcd_clk rises = 11111000 00110000 00000000.
  - Gap to the next frame >= 10 clocks.
REQ-032 Decode all INIT frames -> commands 30,30,0C,01,06,34,36 in order.
  - Gap after 01 >= 20 clocks.
  - led[0] goes 0 after the 36 frame.
REQ-033 Set vram[0]=0xA5, vram[512]=0x3C -> after INIT:
  - commands 80, 80;
  - first data frame 11111010 10100000 01010000;
  - 17th data frame carries 0x3C.
REQ-034 Set vram[16*31+15]=0x81 -> the final DATA of the y=31 group:
  - follows command 0x9F;
  - byte 15 = 0x81.
  - Then the next group starts with command 0x80 and led[1] toggles.
REQ-035 Pull rst_in=0 during bit 10 of a data frame -> next edge gives lcd_clk=0, lcd_data=0.
  - After release the sequence restarts from PWR and INIT.
